// File: rtl/ex.sv
// Execute stage: single-cycle ALU plus an iterative restoring divider that stalls the pipeline.
// Divide results are presented on ex_hi/ex_lo for one cycle with ex_whilo asserted.
module ex #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [3:0]                aluop,
  input  logic [DATA_WIDTH-1:0]     reg1,
  input  logic [DATA_WIDTH-1:0]     reg2,
  input  logic [REG_ADDR_WIDTH-1:0] wd,
  input  logic                      wreg,
  input  logic                      annul,
  output logic [REG_ADDR_WIDTH-1:0] ex_wd,
  output logic                      ex_wreg,
  output logic [DATA_WIDTH-1:0]     ex_wdata,
  output logic                      ex_whilo,
  output logic [DATA_WIDTH-1:0]     ex_hi,
  output logic [DATA_WIDTH-1:0]     ex_lo,
  output logic                      stall_req
);

  localparam int unsigned ShW  = $clog2(DATA_WIDTH);
  localparam int unsigned CntW = $clog2(DATA_WIDTH);

  localparam logic [3:0] OpOr   = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpXor  = 4'd3;
  localparam logic [3:0] OpNor  = 4'd4;
  localparam logic [3:0] OpSll  = 4'd5;
  localparam logic [3:0] OpSrl  = 4'd6;
  localparam logic [3:0] OpSra  = 4'd7;
  localparam logic [3:0] OpAddu = 4'd8;
  localparam logic [3:0] OpSubu = 4'd9;
  localparam logic [3:0] OpSlt  = 4'd10;
  localparam logic [3:0] OpSltu = 4'd11;
  localparam logic [3:0] OpDiv  = 4'd12;
  localparam logic [3:0] OpDivu = 4'd13;

  typedef enum logic [1:0] {StIdle, StDbz, StOn, StEnd} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] dsor_q, dsor_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;

  logic                  is_div, is_signed;
  logic [ShW-1:0]        shamt;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH-1:0] abs1, abs2;
  logic [DATA_WIDTH:0]   trial;

  assign is_div    = (aluop == OpDiv) || (aluop == OpDivu);
  assign is_signed = (aluop == OpDiv);
  assign shamt     = reg1[ShW-1:0];
  assign abs1      = (is_signed && reg1[DATA_WIDTH-1]) ? -reg1 : reg1;
  assign abs2      = (is_signed && reg2[DATA_WIDTH-1]) ? -reg2 : reg2;
  // Shift next dividend bit into the partial remainder and try subtracting the divisor.
  assign trial     = {rem_q, quo_q[DATA_WIDTH-1]} - {1'b0, dsor_q};

  always_comb begin
    alu_res = '0;
    case (aluop)
      OpOr:    alu_res = reg1 | reg2;
      OpAnd:   alu_res = reg1 & reg2;
      OpXor:   alu_res = reg1 ^ reg2;
      OpNor:   alu_res = ~(reg1 | reg2);
      OpSll:   alu_res = reg2 << shamt;
      OpSrl:   alu_res = reg2 >> shamt;
      OpSra:   alu_res = $signed(reg2) >>> shamt;
      OpAddu:  alu_res = reg1 + reg2;
      OpSubu:  alu_res = reg1 - reg2;
      OpSlt:   alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(reg1) < $signed(reg2)};
      OpSltu:  alu_res = {{(DATA_WIDTH-1){1'b0}}, reg1 < reg2};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsor_d    = dsor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    stall_req = 1'b0;
    ex_whilo  = 1'b0;
    ex_hi     = '0;
    ex_lo     = '0;
    ex_wd     = wd;
    ex_wreg   = is_div ? 1'b0 : wreg;
    ex_wdata  = is_div ? '0 : alu_res;

    if (annul) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (is_div) begin
            stall_req = 1'b1;
            cnt_d     = '0;
            rem_d     = '0;
            if (reg2 == '0) begin
              quo_d     = '0;
              neg_quo_d = 1'b0;
              neg_rem_d = 1'b0;
              state_d   = StDbz;
            end else begin
              quo_d     = abs1;
              dsor_d    = abs2;
              neg_quo_d = is_signed && (reg1[DATA_WIDTH-1] ^ reg2[DATA_WIDTH-1]);
              neg_rem_d = is_signed && reg1[DATA_WIDTH-1];
              state_d   = StOn;
            end
          end
        end
        StDbz: begin
          stall_req = 1'b1;
          state_d   = StEnd;
        end
        StOn: begin
          stall_req = 1'b1;
          if (!trial[DATA_WIDTH]) begin
            rem_d = trial[DATA_WIDTH-1:0];
            quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
          end else begin
            rem_d = {rem_q[DATA_WIDTH-2:0], quo_q[DATA_WIDTH-1]};
            quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(DATA_WIDTH - 1)) state_d = StEnd;
        end
        StEnd: begin
          ex_whilo = 1'b1;
          ex_lo    = neg_quo_q ? -quo_q : quo_q;
          ex_hi    = neg_rem_q ? -rem_q : rem_q;
          state_d  = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    if (!reset) begin
      ex_wd     = '0;
      ex_wreg   = 1'b0;
      ex_wdata  = '0;
      ex_whilo  = 1'b0;
      ex_hi     = '0;
      ex_lo     = '0;
      stall_req = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsor_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsor_q    <= dsor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule

// File: tb/tb_ex.sv
// Self-checking bench for the execute stage: ALU vector table, random ALU ops and divides
// against an arithmetic reference model, plus reset/flush/divide-by-zero sequences.
module tb_ex;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  aluop;
  logic [31:0] reg1, reg2;
  logic [4:0]  wd;
  logic        wreg, annul;
  logic [4:0]  ex_wd;
  logic        ex_wreg, ex_whilo, stall_req;
  logic [31:0] ex_wdata, ex_hi, ex_lo;

  int vectors = 0;
  int miscompares = 0;

  ex #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clock(clock), .reset(reset), .aluop(aluop), .reg1(reg1), .reg2(reg2), .wd(wd),
    .wreg(wreg), .annul(annul), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo), .stall_req(stall_req)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ctrl_word();
    return {24'd0, ex_wd, ex_wreg, ex_whilo, stall_req};
  endfunction

  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int unsigned sh;
    longint sa, sb;
    sh = a % 32;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1:  return a | b;
      4'd2:  return a & b;
      4'd3:  return a ^ b;
      4'd4:  return ~(a | b);
      4'd5:  return 32'(longint'(b) * (longint'(1) << sh));
      4'd6:  return b / (32'd1 << sh);
      4'd7:  return (b / (32'd1 << sh)) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      4'd8:  return 32'(longint'(a) + longint'(b));
      4'd9:  return 32'(longint'(a) - longint'(b));
      4'd10: return (sa < sb) ? 32'd1 : 32'd0;
      4'd11: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Reference divide on wide integers: / truncates toward zero, % takes the dividend's sign.
  task automatic model_div(input logic is_signed, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
    longint x, y;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      x = is_signed ? longint'($signed(a)) : longint'({32'd0, a});
      y = is_signed ? longint'($signed(b)) : longint'({32'd0, b});
      q = 32'(x / y);
      r = 32'(x % y);
    end
  endtask

  task automatic apply_alu(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
    logic [4:0] w;
    logic       we;
    w  = 5'($urandom);
    we = 1'($urandom);
    @(posedge clock);
    #1;
    aluop = op; reg1 = a; reg2 = b; wd = w; wreg = we; annul = 1'b0;
    @(negedge clock);
    check({name, " wdata"}, ex_wdata, exp);
    check({name, " ctrl"}, ctrl_word(), {24'd0, w, we, 1'b0, 1'b0});
  endtask

  task automatic run_div(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi);
    int  stalls;
    int  exp_stalls;
    bit  got;
    exp_stalls = (b == 32'd0) ? 2 : 33;
    stalls = 0;
    got = 0;
    @(posedge clock);
    #1;
    aluop = op; reg1 = a; reg2 = b; wd = 5'd9; wreg = 1'b1; annul = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (ex_whilo) begin
        got = 1;
        break;
      end
      if (!stall_req) break;
      stalls++;
      @(posedge clock);
      #1;
      reg1 = $urandom;
      reg2 = $urandom;
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: no HI/LO write seen after %0d stall cycles", name, stalls);
    end else begin
      check({name, " stalls"}, 32'(stalls), 32'(exp_stalls));
      check({name, " lo"}, ex_lo, exp_lo);
      check({name, " hi"}, ex_hi, exp_hi);
      check({name, " end ctrl"}, {ex_wdata[30:0], ex_wreg} | {31'd0, stall_req}, 32'd0);
    end
    @(posedge clock);
    #1;
    aluop = 4'd0;
    @(negedge clock);
    check({name, " idle after"}, {30'd0, ex_whilo, stall_req}, 32'd0);
  endtask

  vec_t tbl[$];

  initial begin
    logic [31:0] q, r, a, b;
    logic [3:0]  op;
    logic        s;
    reset = 1'b0; aluop = 4'd1; reg1 = 32'd1; reg2 = 32'd2; wd = 5'd5; wreg = 1'b1;
    annul = 1'b0;
    @(negedge clock);
    check("reset ctrl", ctrl_word(), 32'd0);
    check("reset wdata", ex_wdata, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    tbl.push_back('{4'd1,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F});
    tbl.push_back('{4'd7,  32'd4,         32'h8000_0000, 32'hF800_0000});
    tbl.push_back('{4'd5,  32'd31,        32'd1,         32'h8000_0000});
    tbl.push_back('{4'd5,  32'd33,        32'd1,         32'd2});
    tbl.push_back('{4'd10, 32'hFFFF_FFFF, 32'd1,         32'd1});
    tbl.push_back('{4'd11, 32'hFFFF_FFFF, 32'd1,         32'd0});
    tbl.push_back('{4'd9,  32'd0,         32'd1,         32'hFFFF_FFFF});
    tbl.push_back('{4'd2,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00});
    tbl.push_back('{4'd3,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F});
    tbl.push_back('{4'd4,  32'hF0F0_0000, 32'h0000_0F0F, 32'h0F0F_F0F0});
    tbl.push_back('{4'd6,  32'd8,         32'h8000_0000, 32'h0080_0000});
    tbl.push_back('{4'd8,  32'hFFFF_FFFF, 32'd2,         32'd1});
    tbl.push_back('{4'd0,  32'd123,       32'd456,       32'd0});
    tbl.push_back('{4'd14, 32'd123,       32'd456,       32'd0});
    foreach (tbl[i])
      apply_alu($sformatf("tbl[%0d] op%0d", i, tbl[i].op), tbl[i].op, tbl[i].a, tbl[i].b,
                tbl[i].exp);

    for (int i = 0; i < 150; i++) begin
      do op = 4'($urandom); while (op == 4'd12 || op == 4'd13);
      a = $urandom;
      b = $urandom;
      apply_alu($sformatf("rand[%0d] op%0d", i, op), op, a, b, model_alu(op, a, b));
    end

    run_div("div -7/2", 4'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("divu ffffffff/16", 4'd13, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'hF);
    run_div("divu x/0", 4'd13, 32'd1234, 32'd0, 32'd0, 32'd0);
    run_div("div min/-1", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_div("div 7/-2", 4'd12, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    for (int i = 0; i < 8; i++) begin
      s = 1'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      model_div(s, a, b, q, r);
      run_div($sformatf("rdiv[%0d]", i), s ? 4'd12 : 4'd13, a, b, q, r);
    end

    // Flush mid-divide.
    @(posedge clock);
    #1;
    aluop = 4'd13; reg1 = 32'd1000; reg2 = 32'd3;
    repeat (10) @(posedge clock);
    #1;
    annul = 1'b1;
    @(negedge clock);
    check("flush same cycle", {30'd0, ex_whilo, stall_req}, 32'd0);
    @(posedge clock);
    #1;
    annul = 1'b0; aluop = 4'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check($sformatf("flush idle %0d", c), {30'd0, ex_whilo, stall_req}, 32'd0);
      @(posedge clock);
      #1;
    end
    run_div("div after flush", 4'd13, 32'd100, 32'd7, 32'd14, 32'd2);

    // Reset during an ON divide.
    @(posedge clock);
    #1;
    aluop = 4'd12; reg1 = 32'd500; reg2 = 32'd9; wd = 5'd3; wreg = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("reset mid-div ctrl", ctrl_word(), 32'd0);
    check("reset mid-div data", ex_wdata | ex_hi | ex_lo, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1; aluop = 4'd8; reg1 = 32'd5; reg2 = 32'd7;
    @(negedge clock);
    check("post-reset addu", ex_wdata, 32'd12);
    check("post-reset stall", {30'd0, ex_whilo, stall_req}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
